// File: rtl/mont_mult_cios.sv
// Word-serial Montgomery multiplier (CIOS ordering).
//   result = a * b * R^-1 mod n, with R = 2^DATA_LENGTH.
// One outer iteration per DATA_WIDTH-bit word of a. Each iteration takes two
// cycles: ITER_A adds a_i*b and ITER_M adds m*n and shifts out one word. A
// FINAL cycle applies the conditional subtraction. Total latency is 2S+1.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      begin an operation; sampled only in IDLE
//   a, b       operands, each < n
//   n          odd modulus
//   n0prime    -n^-1 mod 2^DATA_WIDTH
//   result     registered product; held until the next operation completes
//   busy       high from the cycle after start is accepted until done
//   done       one-cycle pulse; result is valid from this cycle onward
//   state_dbg  current FSM state (0 IDLE, 1 ITER_A, 2 ITER_M, 3 FINAL)
//
// Handshake: start is a request, and the block takes it only while it is idle
// (busy low). The block latches all operands when it accepts the request, so
// the caller may change them on the next cycle. Each accepted request
// produces exactly one done pulse unless rst is asserted before the pulse.
module mont_mult_cios #(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_LENGTH = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_LENGTH-1:0] a,
  input  logic [DATA_LENGTH-1:0] b,
  input  logic [DATA_LENGTH-1:0] n,
  input  logic [DATA_WIDTH-1:0]  n0prime,
  output logic [DATA_LENGTH-1:0] result,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             state_dbg
);

  localparam int S     = DATA_LENGTH / DATA_WIDTH;
  localparam int I_W   = (S > 1) ? $clog2(S) : 1;
  // After ITER_M the accumulator stays below 2n, so it needs DATA_LENGTH+2
  // bits. Between ITER_A and ITER_M it also holds a_i*b and m*n, so the
  // register has DATA_WIDTH extra bits and no carry is lost.
  localparam int ACC_W = DATA_LENGTH + DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ITER_A = 2'd1,
    ITER_M = 2'd2,
    FINAL  = 2'd3
  } state_t;

  state_t                 state_q, state_nx;
  logic [DATA_LENGTH-1:0] a_q, b_q, n_q;
  logic [DATA_WIDTH-1:0]  n0_q;
  logic [ACC_W-1:0]       acc_q;
  logic [I_W-1:0]         i_q;

  logic [DATA_WIDTH-1:0]  a_word;
  logic [DATA_WIDTH-1:0]  m_word;
  logic [ACC_W-1:0]       n_ext;
  logic [ACC_W-1:0]       acc_plus_ab;
  logic [ACC_W-1:0]       acc_red;
  logic                   last_iter;
  logic [DATA_LENGTH-1:0] result_nx;

  assign state_dbg = state_q;

  // Datapath for the current state.
  always_comb begin
    a_word      = DATA_WIDTH'(a_q >> (i_q * DATA_WIDTH));
    n_ext       = ACC_W'(n_q);
    acc_plus_ab = acc_q + ACC_W'(a_word) * ACC_W'(b_q);
    // m makes the low word of acc + m*n zero, so the shift below is exact.
    m_word      = acc_q[DATA_WIDTH-1:0] * n0_q;
    acc_red     = (acc_q + ACC_W'(m_word) * n_ext) >> DATA_WIDTH;
    last_iter   = (i_q == I_W'(S - 1));
    result_nx   = DATA_LENGTH'((acc_q >= n_ext) ? (acc_q - n_ext) : acc_q);
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (start) state_nx = ITER_A;
      ITER_A:  state_nx = ITER_M;
      ITER_M:  state_nx = last_iter ? FINAL : ITER_A;
      FINAL:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      n0_q    <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_nx;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            n_q   <= n;
            n0_q  <= n0prime;
            acc_q <= '0;
            i_q   <= '0;
            busy  <= 1'b1;
          end
        end
        ITER_A: acc_q <= acc_plus_ab;
        ITER_M: begin
          acc_q <= acc_red;
          if (!last_iter) i_q <= i_q + 1'b1;
        end
        FINAL: begin
          result <= result_nx;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mult_cios.sv
// Bench for mont_mult_cios. It builds a 64-bit instance (S=2) for the directed
// vectors and a 1024-bit instance for random operands. The 1024-bit results
// are checked through the identity result*R == a*b (mod n), with result < n.
module tb_mont_mult_cios;

  localparam int W   = 32;
  localparam int L64 = 64;
  localparam int LK  = 1024;
  localparam int LAT64 = 2 * (L64 / W) + 1;
  localparam int LATK  = 2 * (LK / W) + 1;
  localparam logic [63:0] N64 = 64'hFFFF_FFFF_FFFF_FFC5;  // 2^64 - 59

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- 64-bit instance ----------------
  logic          start64;
  logic [63:0]   a64, b64, n64, r64;
  logic [W-1:0]  n0p64;
  logic          busy64, done64;
  logic [1:0]    st64;

  mont_mult_cios #(.DATA_WIDTH(W), .DATA_LENGTH(L64)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .a(a64), .b(b64), .n(n64),
    .n0prime(n0p64), .result(r64), .busy(busy64), .done(done64),
    .state_dbg(st64)
  );

  // ---------------- 1024-bit instance ----------------
  logic          startk;
  logic [LK-1:0] ak, bk, nk, rk;
  logic [W-1:0]  n0pk;
  logic          busyk, donek;
  logic [1:0]    stk;

  mont_mult_cios #(.DATA_WIDTH(W), .DATA_LENGTH(LK)) dutk (
    .clk(clk), .rst(rst), .start(startk), .a(ak), .b(bk), .n(nk),
    .n0prime(n0pk), .result(rk), .busy(busyk), .done(donek),
    .state_dbg(stk)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // -n^-1 mod 2^32 via Newton iteration (x doubles its correct bits each step).
  function automatic logic [31:0] neg_inv(input logic [31:0] v);
    logic [31:0] x;
    x = v;
    for (int k = 0; k < 5; k++) x = x * (32'd2 - v * x);
    return -x;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after the accepting edge. It counts edges until done is
  // seen, giving up after a bound.
  task automatic wait_done64(output int cyc);
    cyc = 0;
    while (!done64 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  // Single start pulse. Checks busy, latency, busy/done exclusion, the result
  // and the one-cycle done pulse.
  task automatic run64(input string tag, input logic [63:0] av, input logic [63:0] bv,
                       input logic [63:0] ev);
    int cyc;
    a64 = av; b64 = bv; start64 = 1'b1;
    tick();
    start64 = 1'b0;
    check({tag, "_busy"}, {63'd0, busy64}, 64'd1);
    wait_done64(cyc);
    check({tag, "_lat"}, 64'(cyc), 64'(LAT64));
    check({tag, "_busy_at_done"}, {63'd0, busy64}, 64'd0);
    check({tag, "_res"}, r64, ev);
    tick();
    check({tag, "_done_pulse"}, {63'd0, done64}, 64'd0);
    check({tag, "_res_hold"}, r64, ev);
  endtask

  // ---------------- 1024-bit random operation ----------------
  task automatic run_rand(input int idx);
    logic [2*LK-1:0] lhs, rhs, n2;
    int cyc;
    for (int k = 0; k < LK / 32; k++) begin
      nk[k*32 +: 32] = $urandom;
      ak[k*32 +: 32] = $urandom;
      bk[k*32 +: 32] = $urandom;
    end
    nk[LK-1] = 1'b1;
    nk[0]    = 1'b1;
    ak = ak % nk;
    bk = bk % nk;
    n0pk = neg_inv(nk[31:0]);
    startk = 1'b1;
    tick();
    startk = 1'b0;
    cyc = 0;
    while (!donek && cyc < 200) begin
      tick();
      cyc++;
    end
    check($sformatf("rand%0d_lat", idx), 64'(cyc), 64'(LATK));
    n2  = {{LK{1'b0}}, nk};
    rhs = ({{LK{1'b0}}, ak} * {{LK{1'b0}}, bk}) % n2;
    lhs = {rk, {LK{1'b0}}} % n2;
    check($sformatf("rand%0d_lt_n", idx), {63'd0, (rk < nk)}, 64'd1);
    check($sformatf("rand%0d_cong", idx), {63'd0, (lhs == rhs)}, 64'd1);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int done_cnt;
    rst = 1'b1;
    start64 = 1'b0; a64 = '0; b64 = '0; n64 = N64; n0p64 = neg_inv(N64[31:0]);
    startk = 1'b0; ak = '0; bk = '0; nk = '0; n0pk = '0;
    tick();
    tick();
    check("rst_result", r64, 64'd0);
    check("rst_busy", {63'd0, busy64}, 64'd0);
    check("rst_done", {63'd0, done64}, 64'd0);
    check("rst_state", {62'd0, st64}, 64'd0);
    rst = 1'b0;
    tick();

    // a = R mod n, so the product reduces to b.
    run64("t1", 64'd59, 64'h1234, 64'h1234);
    run64("t2_zero", 64'd0, N64 - 64'd1, 64'd0);
    run64("t3_rr", 64'd59, 64'd59, 64'd59);
    run64("t3_max", 64'd59, N64 - 64'd1, N64 - 64'd1);

    // A start pulse while busy, with different operands, has no effect.
    a64 = 64'd59; b64 = 64'h5678; start64 = 1'b1;
    tick();
    start64 = 1'b0;
    check("t4_state", {62'd0, st64}, 64'd1);
    tick();
    a64 = 64'd0; b64 = 64'h9999; start64 = 1'b1;
    tick();
    start64 = 1'b0;
    wait_done64(cyc);
    cyc = cyc + 2;
    check("t4_lat", 64'(cyc), 64'(LAT64));
    check("t4_res", r64, 64'h5678);
    tick();

    // Reset during an operation: the operation is dropped and result clears.
    a64 = 64'd59; b64 = 64'h4321; start64 = 1'b1;
    tick();
    start64 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("t5_busy", {63'd0, busy64}, 64'd0);
    check("t5_res", r64, 64'd0);
    tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (done64) done_cnt++;
      tick();
    end
    check("t5_no_done", 64'(done_cnt), 64'd0);
    run64("t5_again", 64'd59, 64'h1234, 64'h1234);

    // start held high through the done cycle gives back-to-back operations.
    a64 = 64'd59; b64 = 64'h1111; start64 = 1'b1;
    tick();
    wait_done64(cyc);
    check("t6_lat1", 64'(cyc), 64'(LAT64));
    check("t6_res1", r64, 64'h1111);
    b64 = 64'h2222;
    tick();
    start64 = 1'b0;
    check("t6_busy2", {63'd0, busy64}, 64'd1);
    wait_done64(cyc);
    check("t6_lat2", 64'(cyc), 64'(LAT64));
    check("t6_res2", r64, 64'h2222);
    tick();

    for (int k = 0; k < 3; k++) run_rand(k);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
